// File: rtl/dmem_responder.sv
// Data-memory responder: single outstanding word request, fixed wait states, byte-lane writes.
// Optional misalignment flagging is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [31:0] mem [DEPTH];

  state_t                state;
  logic [3:0]            cnt;
  logic                  lat_we;
  logic [DEPTH_LOG2-1:0] lat_idx;
  logic [31:0]           lat_wdata;
  logic [3:0]            lat_be;

  logic                  go_resp;
  logic                  cur_we;
  logic [DEPTH_LOG2-1:0] cur_idx;
  logic [31:0]           cur_wdata;
  logic [3:0]            cur_be;
  logic                  cur_mis;
  logic                  unused_addr_bits;

  assign busy = (state != IDLE);

  // With LATENCY=1 the accepting edge is also the edge entering RESP, so the
  // access must use the live request rather than the latched copy.
  assign go_resp = ((state == IDLE) && req && (LATENCY == 1)) ||
                   ((state == WAIT) && (cnt == 4'd1));

  assign cur_we    = (state == IDLE) ? we    : lat_we;
  assign cur_idx   = (state == IDLE) ? addr[DEPTH_LOG2+1:2] : lat_idx;
  assign cur_wdata = (state == IDLE) ? wdata : lat_wdata;
  assign cur_be    = (state == IDLE) ? be    : lat_be;

`ifdef DMEM_ALIGN_CHECK_EN
  logic lat_mis;
  assign cur_mis = (state == IDLE) ? (addr[1:0] != 2'b00) : lat_mis;
`else
  assign cur_mis = 1'b0;
`endif

  assign unused_addr_bits = ^{addr[31:DEPTH_LOG2+2], addr[1:0]};

  always_ff @(posedge clk) begin
    if (!reset_) begin
      state     <= IDLE;
      cnt       <= '0;
      ack       <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      lat_we    <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
`ifdef DMEM_ALIGN_CHECK_EN
      lat_mis   <= 1'b0;
`endif
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            lat_we    <= we;
            lat_idx   <= addr[DEPTH_LOG2+1:2];
            lat_wdata <= wdata;
            lat_be    <= be;
`ifdef DMEM_ALIGN_CHECK_EN
            lat_mis   <= (addr[1:0] != 2'b00);
`endif
            cnt       <= CNT_INIT;
            state     <= (LATENCY > 1) ? WAIT : RESP;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (go_resp) begin
        ack <= 1'b1;
        err <= cur_mis;
        if (cur_mis)      rdata <= '0;
        else if (!cur_we) rdata <= mem[cur_idx];
      end
    end
  end

  // NOTE: the array has no reset so it maps onto RAM; reset only blocks a pending write.
  always_ff @(posedge clk) begin
    if (reset_ && go_resp && cur_we && !cur_mis) begin
      for (int i = 0; i < 4; i++) begin
        if (cur_be[i]) mem[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a transaction-level model checked every cycle,
// plus literal expectations for the directed scenarios and a LATENCY=1 instance.
module tb_dmem_responder;

  localparam int LAT = 2;
  localparam int DL  = 10;

  logic        clk = 1'b0;
  logic        reset_;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        ack, busy, err;

  logic        req1, we1;
  logic [31:0] addr1, wdata1;
  logic [3:0]  be1;
  logic [31:0] rdata1;
  logic        ack1, busy1, err1;

  dmem_responder #(.DEPTH_LOG2(DL), .LATENCY(LAT)) u_dut (
    .clk(clk), .reset_(reset_), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .be(be), .rdata(rdata), .ack(ack), .busy(busy), .err(err)
  );

  dmem_responder #(.DEPTH_LOG2(DL), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset_(reset_), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
    .be(be1), .rdata(rdata1), .ack(ack1), .busy(busy1), .err(err1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;
  int n_ack = 0;

  always @(negedge clk) if (ack === 1'b1) n_ack++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model: a word array, the last read word, and one in-flight request.
  bit [31:0]   mmem [1024];
  logic [31:0] m_rdata;
  bit          inflight = 1'b0;
  bit          chk_on   = 1'b0;
  int          acc;
  bit          t_we;
  logic [31:0] t_addr, t_wdata;
  logic [3:0]  t_be;

  function automatic bit model_apply();
    int idx = int'((t_addr >> 2) % 32'd1024);
    bit mis = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    mis = (t_addr % 32'd4) != 0;
`endif
    if (mis) begin
      m_rdata = '0;
      return 1'b1;
    end
    if (t_we) begin
      for (int i = 0; i < 4; i++)
        if (t_be[i]) mmem[idx][8*i +: 8] = t_wdata[8*i +: 8];
    end else begin
      m_rdata = mmem[idx];
    end
    return 1'b0;
  endfunction

  // Accepted at the edge that made cyc == acc: busy for LAT cycles from then, ack in the last.
  always @(negedge clk) begin : cmp
    bit exp_ack, exp_busy, exp_err;
    exp_ack  = 1'b0;
    exp_busy = 1'b0;
    exp_err  = 1'b0;
    if (chk_on) begin
      if (inflight) begin
        exp_busy = (cyc >= acc) && (cyc <= acc + LAT - 1);
        if (cyc == acc + LAT - 1) begin
          exp_ack  = 1'b1;
          exp_err  = model_apply();
          inflight = 1'b0;
        end
      end
      check("ack",   32'(ack),  32'(exp_ack));
      check("busy",  32'(busy), 32'(exp_busy));
      check("err",   32'(err),  32'(exp_err));
      check("rdata", rdata,     m_rdata);
    end
  end

  task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    @(posedge clk); #1;
    acc = cyc; t_we = w; t_addr = a; t_wdata = d; t_be = b;
    inflight = 1'b1;
    req = 1'b0;
  endtask

  task automatic wait_done();
    int guard = 0;
    while (inflight && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    if (inflight) begin
      n_vec++; n_bad++;
      $display("FAIL ack_timeout: no ack within %0d cycles of acceptance at cycle %0d", guard, acc);
      inflight = 1'b0;
    end
  endtask

  task automatic access(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    issue(w, a, d, b);
    wait_done();
  endtask

  // One request on the LATENCY=1 instance; leaves the bench one cycle after acceptance.
  task automatic issue1(input bit w, input logic [31:0] a, input logic [31:0] d);
    req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; be1 = 4'hF;
    @(posedge clk); #1;
    req1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acks_before;
    reset_ = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0; be1 = '0;
    m_rdata = '0;
    repeat (3) @(posedge clk);
    #1 reset_ = 1'b1;
    chk_on = 1'b1;

    check("reset_busy",  32'(busy), 32'd0);
    check("reset_ack",   32'(ack),  32'd0);
    check("reset_err",   32'(err),  32'd0);
    check("reset_rdata", rdata,     32'd0);

    // Full-word write, then read back; rdata must hold after ack drops.
    access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    check("t1_ack_count", 32'(n_ack), 32'd1);
    access(1'b0, 32'h10, 32'h0, 4'h0);
    check("t2_rdata", rdata, 32'hDEADBEEF);
    @(posedge clk); #1;
    check("t2_rdata_hold", rdata, 32'hDEADBEEF);

    // Single-lane write, then a be=0 write that must not change anything.
    access(1'b1, 32'h10, 32'h0000AA00, 4'b0010);
    access(1'b0, 32'h10, 32'h0, 4'hF);
    check("t3_lane_write", rdata, 32'hDEADAAEF);
    access(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000);
    access(1'b0, 32'h10, 32'h0, 4'h0);
    check("t3_be_zero", rdata, 32'hDEADAAEF);

    // Index wrap, and a req pulse while busy that must be ignored.
    access(1'b0, 32'h1010, 32'h0, 4'h0);
    check("t4_wrap", rdata, 32'hDEADAAEF);
    acks_before = n_ack;
    issue(1'b0, 32'h10, 32'h0, 4'h0);
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    wait_done();
    repeat (3) @(posedge clk);
    #1 check("t4_single_ack", 32'(n_ack - acks_before), 32'd1);

    // Reset during WAIT discards the pending write.
    access(1'b1, 32'h20, 32'hCAFEF00D, 4'hF);
    access(1'b0, 32'h40, 32'h0, 4'h0);
    access(1'b1, 32'h40, 32'h01020304, 4'hF);
    access(1'b0, 32'h40, 32'h0, 4'h0);
    check("t5_nonzero_rdata", rdata, 32'h01020304);
    acks_before = n_ack;
    issue(1'b1, 32'h20, 32'h12345678, 4'hF);
    reset_ = 1'b0;
    @(posedge clk); #1;
    inflight = 1'b0;
    m_rdata  = '0;
    reset_   = 1'b1;
    check("t5_busy_after_reset",  32'(busy),  32'd0);
    check("t5_rdata_after_reset", rdata,      32'd0);
    repeat (3) @(posedge clk);
    #1 check("t5_no_ack", 32'(n_ack - acks_before), 32'd0);
    access(1'b0, 32'h20, 32'h0, 4'h0);
    check("t5_prewrite_value", rdata, 32'hCAFEF00D);

    // Misaligned write on the main instance.
    access(1'b1, 32'h12, 32'h11223344, 4'hF);
    access(1'b0, 32'h10, 32'h0, 4'h0);
`ifdef DMEM_ALIGN_CHECK_EN
    check("t6_misaligned_no_write", rdata, 32'hDEADAAEF);
`else
    check("t6_misaligned_write", rdata, 32'h11223344);
`endif

    // LATENCY=1 instance: ack in the cycle right after acceptance.
    issue1(1'b1, 32'h10, 32'hA5A5A5A5);
    check("l1_ack",  32'(ack1),  32'd1);
    check("l1_busy", 32'(busy1), 32'd1);
    check("l1_err_aligned", 32'(err1), 32'd0);
    @(posedge clk); #1;
    check("l1_ack_drop",  32'(ack1),  32'd0);
    check("l1_busy_drop", 32'(busy1), 32'd0);
    issue1(1'b1, 32'h12, 32'h55667788);
    check("l1_mis_ack", 32'(ack1), 32'd1);
`ifdef DMEM_ALIGN_CHECK_EN
    check("l1_mis_err", 32'(err1), 32'd1);
`else
    check("l1_mis_err", 32'(err1), 32'd0);
`endif
    check("l1_mis_rdata", rdata1, 32'd0);
    @(posedge clk); #1;
    check("l1_err_outside_ack", 32'(err1), 32'd0);
    issue1(1'b0, 32'h10, 32'h0);
    check("l1_read_ack", 32'(ack1), 32'd1);
`ifdef DMEM_ALIGN_CHECK_EN
    check("l1_read_unchanged", rdata1, 32'hA5A5A5A5);
`else
    check("l1_read_written", rdata1, 32'h55667788);
`endif
    @(posedge clk); #1;

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
